fv_stream_collector: RTL and testbench
======================================

// Module: fv_stream_collector
// PURPOSE
// - Downstream of the big-FV bank controllers: collects the per-bank feature-vector stream they emit after stream_begin.
// - Buffers each lane in a small FIFO; round-robin merges lanes into one valid/ready stream for the small-FV buffer.
// - Counts the received words and pulses done once FV_num words have arrived and all FIFOs have drained.
// PARAMETERS
// - NUM_BANKS  4   number of big-FV banks (input lanes)
// - DATA_W     64  FV word width (FV bandwidth)
// - IDX_W      8   FV index width carried with each word
// - DEPTH      4   per-lane FIFO depth, power of 2, >=2
// - MAX_FV     256 max FV count per stream; count width CW=$clog2(MAX_FV)+1
// PORTS
// - clk           in   1                  system clock
// - reset         in   1                  synchronous, active-high reset
// - stream_begin  in   1                  1-cycle pulse: start/restart collection
// - FV_num        in   CW                 words expected this stream; sampled on stream_begin
// - lane_valid    in   NUM_BANKS          per-lane word valid (open loop, no backpressure)
// - lane_data     in   NUM_BANKS*DATA_W   per-lane FV word, lane i at [i*DATA_W +: DATA_W]
// - lane_idx      in   NUM_BANKS*IDX_W    per-lane FV index
// - out_valid     out  1                  merged word valid
// - out_ready     in   1                  consumer accepts when out_valid&&out_ready
// - out_data      out  DATA_W             merged FV word
// - out_idx       out  IDX_W              index of merged word
// - out_bank      out  $clog2(NUM_BANKS)  source lane of merged word
// - busy          out  1                  state != IDLE
// - done          out  1                  1-cycle pulse at end of stream
// - overflow      out  1                  sticky: a word hit a full FIFO
// BEHAVIOUR
// - Reset: state=IDLE; FIFOs empty; rr_ptr=0; rx_cnt=0; all outputs 0.
// - FSM IDLE -> COLLECT on stream_begin. The same cycle flushes all FIFOs, clears rx_cnt and overflow, and latches FV_num.
// - COLLECT:
//   - Every asserted lane_valid adds 1 to rx_cnt. Simultaneous lanes add popcount(lane_valid).
//   - rx_cnt saturates at MAX_FV.
//   - A word is pushed into its lane FIFO unless that FIFO is full. If full, the word is dropped and overflow=1.
//   - Dropped words still count toward rx_cnt so the stream terminates.
//   - A push to a full FIFO that pops in the same cycle is accepted.
//   - Transition to DRAIN when rx_cnt+popcount >= latched FV_num. This includes FV_num=0, which moves to DRAIN on the next cycle.
// - DRAIN: lane_valid is ignored. Go to DONE when all FIFOs are empty and no pop is pending.
// - DONE: done=1 for exactly one cycle, then IDLE.
// - In IDLE and DONE, lane_valid is ignored and produces no count.
// - stream_begin in any non-IDLE state restarts: flush, re-latch, go to COLLECT. No done pulse is issued for the aborted stream.
// - Output merge:
//   - out_valid=1 when any FIFO is non-empty.
//   - Grant goes to the first non-empty lane at or after rr_ptr.
//   - out_* show that lane's head combinationally from FIFO registers.
//   - On a handshake, pop the granted lane and set rr_ptr=granted+1 (mod NUM_BANKS).
//   - out_* stay stable while out_valid&&!out_ready (the grant is held).
// - Latency: a word pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
// - FIFO: wrap-around read/write pointers with an extra MSB to distinguish full from empty.
// CONFIGURATION
// - FV_COLLECT_STATS_EN defined:
//   - Adds outputs stall_cnt[31:0] and drop_cnt[CW-1:0], both cleared on reset and on stream_begin.
//   - stall_cnt counts cycles with out_valid&&!out_ready. It saturates.
//   - drop_cnt counts dropped words. It saturates.
// - FV_COLLECT_STATS_EN undefined: these ports and their counters do not exist; all other behaviour is identical.
// TESTING
// - Reset, then FV_num=4, one word per lane in a single cycle, out_ready=1:
//   - Output order is lanes 0,1,2,3 on consecutive cycles.
//   - done pulses 1 cycle after the last pop.
//   - overflow=0.
// - FV_num=0 with stream_begin: busy for 2 cycles, done pulse, no out_valid.
// - out_ready=0, 6 words on lane 2 with DEPTH=4:
//   - 4 words are buffered and overflow=1.
//   - Release ready: 4 words emerge with idx intact, then done.
// - Lanes 0 and 3 valid every cycle, out_ready=1: grants alternate 0,3,0,3 (fair round-robin).
// - stream_begin re-pulsed mid-COLLECT with 2 words buffered: FIFOs flush, no done pulse, the new FV_num governs termination.
// - Stats build: 3 stall cycles and 2 drops give stall_cnt=3 and drop_cnt=2; both read 0 after the next stream_begin.

Source files
------------

// File: rtl/fv_stream_collector_if.sv
// Lane-side word inputs and merged output stream of fv_stream_collector.
// The master modport is the collector's view; slave is the environment's view.
interface fv_stream_collector_if #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int IDX_W     = 8
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_BANKS-1:0]        lane_valid;
    logic [NUM_BANKS*DATA_W-1:0] lane_data;
    logic [NUM_BANKS*IDX_W-1:0]  lane_idx;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_data;
    logic [IDX_W-1:0]            out_idx;
    logic [BW-1:0]               out_bank;

    modport master (
        input  lane_valid, lane_data, lane_idx, out_ready,
        output out_valid, out_data, out_idx, out_bank
    );

    modport slave (
        output lane_valid, lane_data, lane_idx, out_ready,
        input  out_valid, out_data, out_idx, out_bank
    );
endinterface

// File: rtl/fv_stream_collector.sv
// Collects per-bank FV words into lane FIFOs and round-robin merges them into one stream.
// Optional FV_COLLECT_STATS_EN adds stall_cnt/drop_cnt statistics outputs.
module fv_stream_collector #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int IDX_W     = 8,
    parameter int DEPTH     = 4,
    parameter int MAX_FV    = 256,
    localparam int CW       = $clog2(MAX_FV) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stream_begin,
    input  logic [CW-1:0]          FV_num,
    fv_stream_collector_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
`ifdef FV_COLLECT_STATS_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [CW-1:0]          drop_cnt
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PCW = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    state_t state;

    logic [DATA_W-1:0] fifo_data [NUM_BANKS][DEPTH];
    logic [IDX_W-1:0]  fifo_idx  [NUM_BANKS][DEPTH];
    logic [AW:0]       wr_ptr    [NUM_BANKS];
    logic [AW:0]       rd_ptr    [NUM_BANKS];
    logic [AW:0]       occ       [NUM_BANKS];

    logic [BW-1:0]        rr_ptr, grant, hold_lane, scan_lane;
    logic                 hold_valid, found, handshake, collecting, drain_empty;
    logic [CW-1:0]        rx_cnt, fv_num_q;
    logic [CW:0]          rx_sum;
    logic [PCW-1:0]       lane_cnt;
    logic [NUM_BANKS-1:0] nonempty, full, last_word, pop, push_req, push, drop;
`ifdef FV_COLLECT_STATS_EN
    logic [PCW-1:0]       drop_pop;
    logic [CW:0]          drop_sum;
`endif

    // A stalled grant is latched so a late push to a higher-priority lane cannot change out_*.
    always_comb begin
        found     = 1'b0;
        grant     = rr_ptr;
        scan_lane = rr_ptr;
        for (int i = 0; i < NUM_BANKS; i++) begin
            occ[i]       = wr_ptr[i] - rd_ptr[i];
            nonempty[i]  = (wr_ptr[i] != rd_ptr[i]);
            full[i]      = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                           (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            last_word[i] = (occ[i] == (AW+1)'(1));
        end
        if (hold_valid) begin
            grant = hold_lane;
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                scan_lane = BW'((int'(rr_ptr) + k) % NUM_BANKS);
                if (!found && nonempty[scan_lane]) begin
                    grant = scan_lane;
                    found = 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = |nonempty;
    assign bus.out_data  = fifo_data[grant][rd_ptr[grant][AW-1:0]];
    assign bus.out_idx   = fifo_idx[grant][rd_ptr[grant][AW-1:0]];
    assign bus.out_bank  = grant;
    assign handshake     = bus.out_valid && bus.out_ready;
    assign collecting    = (state == COLLECT) && !stream_begin;

    // Full FIFOs still accept a word when the same lane pops this cycle.
    always_comb begin
        lane_cnt = '0;
`ifdef FV_COLLECT_STATS_EN
        drop_pop = '0;
`endif
        for (int i = 0; i < NUM_BANKS; i++) begin
            pop[i]      = handshake && (grant == BW'(i));
            push_req[i] = collecting && bus.lane_valid[i];
            push[i]     = push_req[i] && (!full[i] || pop[i]);
            drop[i]     = push_req[i] && full[i] && !pop[i];
            lane_cnt    = lane_cnt + PCW'(push_req[i]);
`ifdef FV_COLLECT_STATS_EN
            drop_pop    = drop_pop + PCW'(drop[i]);
`endif
        end
        rx_sum      = {1'b0, rx_cnt} + (CW+1)'(lane_cnt);
        drain_empty = &(~nonempty | (last_word & pop));
`ifdef FV_COLLECT_STATS_EN
        drop_sum    = {1'b0, drop_cnt} + (CW+1)'(drop_pop);
`endif
    end

    // stream_begin is applied last so it overrides every other update, in any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            rr_ptr     <= '0;
            rx_cnt     <= '0;
            fv_num_q   <= '0;
            hold_valid <= 1'b0;
            hold_lane  <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
`ifdef FV_COLLECT_STATS_EN
            stall_cnt  <= '0;
            drop_cnt   <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (push[i]) begin
                    fifo_data[i][wr_ptr[i][AW-1:0]] <= bus.lane_data[i*DATA_W +: DATA_W];
                    fifo_idx[i][wr_ptr[i][AW-1:0]]  <= bus.lane_idx[i*IDX_W +: IDX_W];
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            if (handshake) begin
                rr_ptr <= (int'(grant) == NUM_BANKS - 1) ? '0 : grant + 1'b1;
            end
            hold_valid <= bus.out_valid && !bus.out_ready;
            hold_lane  <= grant;
            done       <= 1'b0;
            if (|drop) begin
                overflow <= 1'b1;
            end
`ifdef FV_COLLECT_STATS_EN
            if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            drop_cnt <= drop_sum[CW] ? '1 : drop_sum[CW-1:0];
`endif
            case (state)
                COLLECT: begin
                    rx_cnt <= (rx_sum > (CW+1)'(MAX_FV)) ? CW'(MAX_FV) : rx_sum[CW-1:0];
                    if (rx_sum >= {1'b0, fv_num_q}) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
            if (stream_begin) begin
                state      <= COLLECT;
                busy       <= 1'b1;
                done       <= 1'b0;
                overflow   <= 1'b0;
                rx_cnt     <= '0;
                fv_num_q   <= FV_num;
                hold_valid <= 1'b0;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end
`ifdef FV_COLLECT_STATS_EN
                stall_cnt  <= '0;
                drop_cnt   <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fv_stream_collector.sv
// Directed testbench for fv_stream_collector: ordering, FV_num=0, overflow, fairness, restart.
module tb_fv_stream_collector;
    localparam int NUM_BANKS = 4;
    localparam int DATA_W    = 64;
    localparam int IDX_W     = 8;
    localparam int DEPTH     = 4;
    localparam int MAX_FV    = 256;
    localparam int CW        = $clog2(MAX_FV) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          stream_begin;
    logic [CW-1:0] fv_num;
    logic          busy, done, overflow;
`ifdef FV_COLLECT_STATS_EN
    logic [31:0]   stall_cnt;
    logic [CW-1:0] drop_cnt;
`endif

    int check_count = 0;
    int error_count = 0;

    fv_stream_collector_if #(.NUM_BANKS(NUM_BANKS), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus_if ();

    fv_stream_collector #(
        .NUM_BANKS(NUM_BANKS), .DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .MAX_FV(MAX_FV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stream_begin(stream_begin),
        .FV_num(fv_num),
        .bus(bus_if),
        .busy(busy),
        .done(done),
        .overflow(overflow)
`ifdef FV_COLLECT_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [IDX_W-1:0] expIdx(input int lane, input int seq);
        return IDX_W'(lane * 64 + seq);
    endfunction

    function automatic logic [DATA_W-1:0] expData(input int lane, input int seq);
        return 64'hD000_0000_0000_0000 | (64'(lane) << 16) | 64'(seq);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_BANKS-1:0] valid, input int seq);
        bus_if.lane_valid = valid;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bus_if.lane_idx[i*IDX_W +: IDX_W]    = expIdx(i, seq);
            bus_if.lane_data[i*DATA_W +: DATA_W] = expData(i, seq);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startStream(input int n);
        stream_begin = 1'b1;
        fv_num       = CW'(n);
        step();
        stream_begin = 1'b0;
    endtask

    task automatic checkHead(input string tag, input int lane, input int seq);
        checkOutput({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
        checkOutput({tag, "_bank"}, 64'(bus_if.out_bank), 64'(lane));
        checkOutput({tag, "_idx"}, 64'(bus_if.out_idx), 64'(expIdx(lane, seq)));
        checkOutput({tag, "_data"}, bus_if.out_data, expData(lane, seq));
    endtask

    initial begin
        reset            = 1'b1;
        stream_begin     = 1'b0;
        fv_num           = '0;
        bus_if.out_ready = 1'b0;
        applyStimulus('0, 0);
        repeat (3) step();
        reset = 1'b0;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);
        checkOutput("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
`ifdef FV_COLLECT_STATS_EN
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif

        $display("[TB] one word per lane, FV_num=4");
        bus_if.out_ready = 1'b1;
        startStream(4);
        applyStimulus(4'b1111, 0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        checkOutput("t1_no_early_valid", 64'(bus_if.out_valid), 64'd0);
        step();
        applyStimulus('0, 0);
        for (int k = 0; k < 4; k++) begin
            checkHead("t1_head", k, 0);
            checkOutput("t1_done_early", 64'(done), 64'd0);
            step();
        end
        checkOutput("t1_done", 64'(done), 64'd1);
        checkOutput("t1_empty", 64'(bus_if.out_valid), 64'd0);
        checkOutput("t1_overflow", 64'(overflow), 64'd0);
        step();
        checkOutput("t1_done_pulse", 64'(done), 64'd0);
        checkOutput("t1_idle", 64'(busy), 64'd0);

        $display("[TB] FV_num=0");
        startStream(0);
        checkOutput("t2_busy_c1", 64'(busy), 64'd1);
        checkOutput("t2_done_c1", 64'(done), 64'd0);
        step();
        checkOutput("t2_busy_c2", 64'(busy), 64'd1);
        checkOutput("t2_done_c2", 64'(done), 64'd0);
        checkOutput("t2_valid_c2", 64'(bus_if.out_valid), 64'd0);
        step();
        checkOutput("t2_done", 64'(done), 64'd1);
        checkOutput("t2_valid", 64'(bus_if.out_valid), 64'd0);
        step();
        checkOutput("t2_idle", 64'(busy), 64'd0);

        $display("[TB] overflow on lane 2 with out_ready low");
        bus_if.out_ready = 1'b0;
        startStream(6);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0100, k);
            step();
        end
        applyStimulus('0, 0);
        checkOutput("t3_overflow", 64'(overflow), 64'd1);
        checkHead("t3_stalled", 2, 0);
        checkOutput("t3_done_early", 64'(done), 64'd0);
        step();
`ifdef FV_COLLECT_STATS_EN
        checkOutput("t3_stall_cnt", 64'(stall_cnt), 64'd6);
        checkOutput("t3_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkHead("t3_head", 2, k);
            step();
        end
        checkOutput("t3_done", 64'(done), 64'd1);
        checkOutput("t3_overflow_sticky", 64'(overflow), 64'd1);
        checkOutput("t3_empty", 64'(bus_if.out_valid), 64'd0);
        step();

        $display("[TB] lanes 0 and 3 every cycle, round-robin");
        startStream(8);
        applyStimulus(4'b1001, 0);
        checkOutput("t4_overflow_clear", 64'(overflow), 64'd0);
`ifdef FV_COLLECT_STATS_EN
        checkOutput("t4_stall_clear", 64'(stall_cnt), 64'd0);
        checkOutput("t4_drop_clear", 64'(drop_cnt), 64'd0);
`endif
        for (int k = 0; k < 8; k++) begin
            step();
            if (k + 2 <= 4) applyStimulus(4'b1001, k + 1);
            else            applyStimulus('0, 0);
            checkHead("t4_rr", (k % 2 == 0) ? 3 : 0, k / 2);
            checkOutput("t4_done_early", 64'(done), 64'd0);
        end
        step();
        checkOutput("t4_done", 64'(done), 64'd1);
        checkOutput("t4_overflow", 64'(overflow), 64'd0);
        step();

        $display("[TB] restart mid-collect");
        bus_if.out_ready = 1'b0;
        startStream(10);
        applyStimulus(4'b0011, 0);
        step();
        applyStimulus('0, 0);
        checkHead("t5_buffered", 1, 0);
        startStream(3);
        checkOutput("t5_flushed", 64'(bus_if.out_valid), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd1);
        checkOutput("t5_no_done", 64'(done), 64'd0);
`ifdef FV_COLLECT_STATS_EN
        checkOutput("t5_stall_clear", 64'(stall_cnt), 64'd0);
`endif
        bus_if.out_ready = 1'b1;
        applyStimulus(4'b0001, 5);
        step();
        applyStimulus(4'b0010, 6);
        checkHead("t5_w0", 0, 5);
        step();
        applyStimulus(4'b0100, 7);
        checkHead("t5_w1", 1, 6);
        checkOutput("t5_done_early", 64'(done), 64'd0);
        step();
        applyStimulus('0, 0);
        checkHead("t5_w2", 2, 7);
        checkOutput("t5_done_early2", 64'(done), 64'd0);
        step();
        checkOutput("t5_done", 64'(done), 64'd1);
        step();
        checkOutput("t5_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
